// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if
//   Groups the event/level signals of pulse_stretcher.
//   pulse_in   : event strobe, one event per sampled high cycle
//   signal_out : stretched output level
//   busy       : stretcher is not idle
//   pending    : queued events not yet started
//   overflow   : one-cycle flag, an event was dropped
//   master modport drives pulse_in; slave modport is the stretcher side.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic              signal_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in,
        input  signal_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output signal_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event pulses into fixed-width high periods, each
//   followed by a mandatory low gap. Events arriving while a period is in
//   progress are queued in a saturating counter; an event arriving with the
//   queue full is dropped and flagged on overflow for one cycle.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pulse_stretcher_if.slave (pulse_in in; signal_out, busy,
//           pending, overflow out, all registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in progress, output low, waiting for an event
// HIGH  | output high, cnt counts the remaining high cycles down to 0
// GAP   | output low, cnt counts the remaining gap cycles down to 0
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 128,
    parameter int GAP_CYCLES  = 128,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    pulse_stretcher_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pend_q;
    logic              sig_q;
    logic              busy_q;
    logic              ovf_q;

    logic cnt_zero;
    logic restart;
    logic queue_evt;

    assign cnt_zero = (cnt == '0);

    // Restart when the gap expires with a queued event or a fresh pulse in
    // the same cycle; a fresh pulse then starts the period directly instead
    // of passing through the queue.
    assign restart = (state == GAP) && cnt_zero &&
                     ((pend_q != '0) || bus.pulse_in);

    // On a restart cycle an incoming pulse cancels the dequeue, so it never
    // counts as a queue increment (and therefore never overflows).
    assign queue_evt = bus.pulse_in && (state != IDLE) && !restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            pend_q <= '0;
            sig_q  <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= 1'b0;

            if (queue_evt) begin
                if (pend_q == PEND_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    pend_q <= pend_q + PEND_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (bus.pulse_in) begin
                        state  <= HIGH;
                        cnt    <= HIGH_LOAD;
                        sig_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                        sig_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (restart) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        sig_q <= 1'b1;
                        if ((pend_q != '0) && !bus.pulse_in) begin
                            pend_q <= pend_q - PEND_W'(1);
                        end
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    sig_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.signal_out = sig_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = pend_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
//   Two stretchers share clk/reset: dut_a (HIGH=4, GAP=2, PEND_W=2) and
//   dut_b (HIGH=1, GAP=1, PEND_W=2). Each cycle a reference model predicts
//   the outputs, the prediction is queued, and it is popped and compared
//   after the clock edge. Directed checks pin down the test-plan timings.
module tb_pulse_stretcher;

    logic clk;
    logic reset;

    pulse_stretcher_if #(.PEND_W(2)) ifa ();
    pulse_stretcher_if #(.PEND_W(2)) ifb ();

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .PEND_W(2))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

    pulse_stretcher #(.HIGH_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8), .PEND_W(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;    // 0 idle, 1 high, 2 gap
        int cnt;
        int pend;
        bit sig;
        bit busy;
        bit ovf;
    } mdl_t;

    typedef struct {
        int a_sig, a_busy, a_pend, a_ovf;
        int b_sig, b_busy, b_pend, b_ovf;
    } exp_t;

    mdl_t ma, mb;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour written in terms of the effective queue depth
    // (queued events plus a same-cycle pulse) at the end of each gap.
    function automatic mdl_t step(input mdl_t m, input bit p, input int hi,
                                  input int gap, input int pmax);
        mdl_t n = m;
        bit   add = 1'b0;
        n.ovf = 1'b0;
        case (m.st)
            0: if (p) begin n.st = 1; n.cnt = hi - 1; end
            1: begin
                add = p;
                if (m.cnt == 0) begin n.st = 2; n.cnt = gap - 1; end
                else n.cnt = m.cnt - 1;
            end
            default: begin
                if (m.cnt != 0) begin
                    n.cnt = m.cnt - 1;
                    add   = p;
                end else if (m.pend + int'(p) > 0) begin
                    n.st   = 1;
                    n.cnt  = hi - 1;
                    n.pend = m.pend + int'(p) - 1;
                end else begin
                    n.st = 0;
                end
            end
        endcase
        if (add) begin
            if (m.pend == pmax) n.ovf = 1'b1;
            else n.pend = m.pend + 1;
        end
        n.sig  = (n.st == 1);
        n.busy = (n.st != 0);
        return n;
    endfunction

    // Entered and left at a falling edge.
    task automatic tick(input bit pa, input bit pb);
        exp_t e;
        ifa.pulse_in = pa;
        ifb.pulse_in = pb;
        ma = step(ma, pa, 4, 2, 3);
        mb = step(mb, pb, 1, 1, 3);
        e.a_sig = ma.sig;  e.a_busy = ma.busy; e.a_pend = ma.pend; e.a_ovf = ma.ovf;
        e.b_sig = mb.sig;  e.b_busy = mb.busy; e.b_pend = mb.pend; e.b_ovf = mb.ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("a_sig",  ifa.signal_out, e.a_sig);
            check("a_busy", ifa.busy,       e.a_busy);
            check("a_pend", ifa.pending,    e.a_pend);
            check("a_ovf",  ifa.overflow,   e.a_ovf);
            check("b_sig",  ifb.signal_out, e.b_sig);
            check("b_busy", ifb.busy,       e.b_busy);
            check("b_pend", ifb.pending,    e.b_pend);
            check("b_ovf",  ifb.overflow,   e.b_ovf);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int   rise[$];
        int   ovf_at[$];
        int   maxp;
        logic prev;
        int   exp_p[6];

        ma = '{default: 0};
        mb = '{default: 0};
        ifa.pulse_in = 1'b0;
        ifb.pulse_in = 1'b0;
        reset = 1'b0;

        #2;
        check("rst_a_sig",  ifa.signal_out, 0);
        check("rst_a_busy", ifa.busy,       0);
        check("rst_a_pend", ifa.pending,    0);
        check("rst_a_ovf",  ifa.overflow,   0);
        check("rst_b_sig",  ifb.signal_out, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain(3);

        // single event
        tick(1'b1, 1'b0);
        check("single_sig0",  ifa.signal_out, 1);
        check("single_busy0", ifa.busy,       1);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b0);
            check("single_sig",  ifa.signal_out, (i < 4) ? 1 : 0);
            check("single_busy", ifa.busy,       (i < 6) ? 1 : 0);
            check("single_pend", ifa.pending,    0);
        end
        drain(3);

        // queued events at relative ticks 0, 2, 3
        rise.delete();
        prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick((i == 0) || (i == 2) || (i == 3), 1'b0);
            if (ifa.signal_out && !prev) rise.push_back(i);
            prev = ifa.signal_out;
            if (i == 3)  check("queued_pend2", ifa.pending, 2);
            if (i == 6)  check("queued_pend1", ifa.pending, 1);
            if (i == 12) check("queued_pend0", ifa.pending, 0);
        end
        check("queued_periods", rise.size(), 3);
        if (rise.size() == 3) begin
            check("queued_rise0", rise[0], 0);
            check("queued_rise1", rise[1], 6);
            check("queued_rise2", rise[2], 12);
        end
        drain(3);

        // overflow: five back-to-back pulses
        rise.delete();
        ovf_at.delete();
        prev = 1'b0;
        maxp = 0;
        for (int i = 0; i < 32; i++) begin
            tick(i < 5, 1'b0);
            if (ifa.signal_out && !prev) rise.push_back(i);
            prev = ifa.signal_out;
            if (ifa.overflow) ovf_at.push_back(i);
            if (int'(ifa.pending) > maxp) maxp = int'(ifa.pending);
        end
        check("ovf_periods", rise.size(), 4);
        check("ovf_maxpend", maxp, 3);
        check("ovf_count",   ovf_at.size(), 1);
        if (ovf_at.size() == 1) check("ovf_tick", ovf_at[0], 4);
        drain(3);

        // simultaneous increment and decrement at max (restart at tick 6)
        rise.delete();
        prev = 1'b0;
        for (int i = 0; i < 34; i++) begin
            tick((i < 4) || (i == 6), 1'b0);
            if (ifa.signal_out && !prev) rise.push_back(i);
            prev = ifa.signal_out;
            if (i == 3) check("simul_pend_pre", ifa.pending, 3);
            if (i == 6) begin
                check("simul_sig",  ifa.signal_out, 1);
                check("simul_pend", ifa.pending,    3);
                check("simul_ovf",  ifa.overflow,   0);
            end
        end
        check("simul_periods", rise.size(), 5);
        drain(3);

        // reset mid-HIGH with two queued events
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("rmid_pend_pre", ifa.pending,    2);
        check("rmid_sig_pre",  ifa.signal_out, 1);
        ifa.pulse_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rmid_sig",  ifa.signal_out, 0);
        check("rmid_busy", ifa.busy,       0);
        check("rmid_pend", ifa.pending,    0);
        ma = '{default: 0};
        mb = '{default: 0};
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            check("rmid_quiet", ifa.signal_out, 0);
        end

        // minimum parameters: continuous pulses into dut_b
        exp_p = '{0, 1, 1, 2, 2, 3};
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            check("min_sig",  ifb.signal_out, (i % 2 == 0) ? 1 : 0);
            check("min_pend", ifb.pending,    exp_p[i]);
            check("min_ovf",  ifb.overflow,   0);
        end
        drain(12);
        check("min_idle", ifb.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
